// File: rtl/nibble_borrow_subtractor_pkg.sv
// rtl/nibble_borrow_subtractor_pkg.sv - shared types, constants and helpers for the nibble borrow subtractor
//
// Purpose: FSM state encoding, nibble width and the signed-overflow rule
// shared by the top level and its bench.
// Ports: none (package).
// Optional feature macro used elsewhere: NIBBLE_BORROW_SUBTRACTOR_CMP_EN.

package nibble_borrow_subtractor_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Subtraction overflows only when the operands differ in sign and the
  // result's sign differs from the minuend's.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/nibble_borrow_subtractor_la4.sv
// rtl/nibble_borrow_subtractor_la4.sv - combinational 4-bit borrow-look-ahead cell
//
// Purpose: d = a - b - bi over one nibble, all borrows computed in parallel.
// Ports:
//   a  [3:0] in   minuend nibble
//   b  [3:0] in   subtrahend nibble
//   bi       in   borrow-in
//   d  [3:0] out  difference nibble
//   bo       out  borrow-out

module borrow_la4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_br;

  // p: a borrow arriving at this bit passes through (a == b).
  // g: this bit borrows on its own (a=0, b=1).
  assign w_p = ~(a ^ b);
  assign w_g = ~a & b;

  assign w_br[0] = bi;
  assign w_br[1] = w_g[0] | (w_p[0] & bi);
  assign w_br[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bi);
  assign w_br[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & bi);
  assign w_br[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bi);

  assign d  = a ^ b ^ w_br[3:0];
  assign bo = w_br[4];

endmodule

// File: rtl/nibble_borrow_subtractor.sv
// rtl/nibble_borrow_subtractor.sv - multi-cycle WIDTH-bit subtractor, one nibble per clock
//
// Purpose: diff = a - b - bin, LSB nibble first through one shared
// borrow-look-ahead cell, borrow registered between nibbles.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request, sampled only while busy=0
//   a, b [W-1:0] in   operands, captured on accepted start
//   bin          in   borrow-in, captured on accepted start
//   busy         out  subtraction in progress
//   done         out  one-cycle result-valid pulse
//   diff [W-1:0] out  result, held until next completion
//   bout         out  final borrow-out (unsigned a < b+bin)
//   ovf          out  signed overflow
//   eq/ltu/lts   out  compare flags, only with NIBBLE_BORROW_SUBTRACTOR_CMP_EN

module nibble_borrow_subtractor
  import nibble_borrow_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
`ifdef NIBBLE_BORROW_SUBTRACTOR_CMP_EN
  ,
  output logic             eq,
  output logic             ltu,
  output logic             lts
`endif
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
    $error("nibble_borrow_subtractor: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic [WIDTH-1:0]      r_work;
  logic [WIDTH-1:0]      w_work_next;
  logic                  r_borrow;
  logic [IDX_W-1:0]      r_idx;
  logic [WIDTH-1:0]      r_diff;
  logic                  r_bout;
  logic                  r_ovf;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_ovf_final;
  logic [NIBBLE_W-1:0]   w_a_nib;
  logic [NIBBLE_W-1:0]   w_b_nib;
  logic [NIBBLE_W-1:0]   w_d_nib;
  logic                  w_bo;

  // DONE counts as not busy, so a start there chains straight into RUN.
  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_idx == IDX_W'(NIB - 1));
  assign w_a_nib  = r_a[int'(r_idx) * NIBBLE_W +: NIBBLE_W];
  assign w_b_nib  = r_b[int'(r_idx) * NIBBLE_W +: NIBBLE_W];

  borrow_la4 u_la4 (
    .a  (w_a_nib),
    .b  (w_b_nib),
    .bi (r_borrow),
    .d  (w_d_nib),
    .bo (w_bo)
  );

  // Working value including the nibble being computed this cycle, so the
  // final nibble can be published directly on the transition into DONE.
  always_comb begin
    w_work_next = r_work;
    w_work_next[int'(r_idx) * NIBBLE_W +: NIBBLE_W] = w_d_nib;
  end

  assign w_ovf_final = signed_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_work_next[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_borrow <= 1'b0;
      r_idx    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_idx    <= '0;
    end else if (r_state == RUN) begin
      r_work   <= w_work_next;
      r_borrow <= w_bo;
      r_idx    <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_diff <= w_work_next;
        r_bout <= w_bo;
        r_ovf  <= w_ovf_final;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

`ifdef NIBBLE_BORROW_SUBTRACTOR_CMP_EN
  logic r_eq;
  logic r_ltu;
  logic r_lts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eq  <= 1'b0;
      r_ltu <= 1'b0;
      r_lts <= 1'b0;
    end else if (!w_accept && (r_state == RUN) && w_last) begin
      r_eq  <= (w_work_next == '0) && !w_bo;
      r_ltu <= w_bo;
      r_lts <= w_work_next[WIDTH-1] ^ w_ovf_final;
    end
  end

  assign eq  = r_eq;
  assign ltu = r_ltu;
  assign lts = r_lts;
`endif

endmodule

// File: tb/tb_nibble_borrow_subtractor.sv
// tb/tb_nibble_borrow_subtractor.sv - self-checking bench for nibble_borrow_subtractor (WIDTH=16)

module tb_nibble_borrow_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
`ifdef NIBBLE_BORROW_SUBTRACTOR_CMP_EN
  logic         eq;
  logic         ltu;
  logic         lts;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_borrow_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
`ifdef NIBBLE_BORROW_SUBTRACTOR_CMP_EN
    ,
    .eq    (eq),
    .ltu   (ltu),
    .lts   (lts)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: true integer arithmetic, then wrap / range tests.
  task automatic check_result(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    int ua, ub, sa, sb, ur, sr;
    logic [W-1:0] e_diff;
    ua = ta;
    ub = tb_v;
    sa = $signed(ta);
    sb = $signed(tb_v);
    ur = ua - ub - int'(tbin);
    sr = sa - sb - int'(tbin);
    e_diff = W'(ur);
    check("diff", diff, e_diff);
    check("bout", bout, ur < 0);
    check("ovf", ovf, (sr < -(1 << (W - 1))) || (sr >= (1 << (W - 1))));
`ifdef NIBBLE_BORROW_SUBTRACTOR_CMP_EN
    check("eq", eq, ur == 0);
    check("ltu", ltu, ur < 0);
    check("lts", lts, sr < 0);
`endif
  endtask

  task automatic wait_done(input bit keep_start, output int n_edges, output int n_busy,
                           output bit first_busy, output bit changed);
    logic [W-1:0] d0;
    logic bo0, ov0;
    d0 = diff;
    bo0 = bout;
    ov0 = ovf;
    n_edges = 0;
    n_busy = 0;
    first_busy = 0;
    changed = 0;
    do begin
      @(posedge clk);
      #1;
      n_edges++;
      if (n_edges == 1) begin
        first_busy = busy;
        if (!keep_start) start = 1'b0;
      end
      if (busy) n_busy++;
      if (!done && (diff !== d0 || bout !== bo0 || ovf !== ov0)) changed = 1;
    end while (!done && n_edges < 20);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input bit keep);
    int ne, nb;
    bit fb, ch;
    a = ta;
    b = tb_v;
    bin = tbin;
    start = 1'b1;
    wait_done(keep, ne, nb, fb, ch);
    check("latency", ne, 5);
    check("busy_cycles", nb, 4);
    check("busy_after_start", fb, 1);
    check("result_held_in_run", ch, 0);
    check_result(ta, tb_v, tbin);
  endtask

  initial begin
    int n_done;
    logic [W-1:0] first_d;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(16'h1234, 16'h0234, 1'b0, 1'b0);
    check("tp1_diff", diff, 16'h1000);
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
    check("tp2_diff", diff, 16'hFFFF);
    check("tp2_bout", bout, 1);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0);
    check("tp3_diff", diff, 16'h7FFF);
    check("tp3_ovf", ovf, 1);
    run_op(16'h00F0, 16'h000F, 1'b1, 1'b0);
    check("tp4_diff", diff, 16'h00E0);
    run_op(16'h5A5A, 16'h5A5A, 1'b0, 1'b0);
    check("tp5_diff", diff, 16'h0000);

    // start during RUN is ignored; operand changes after capture do nothing
    a = 16'h0005;
    b = 16'h0003;
    bin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'hFFFF;
    b = 16'h0000;
    bin = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_done = 0;
    first_d = '0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (n_done == 1) first_d = diff;
      end
    end
    check("ignored_start_done_count", n_done, 1);
    check("ignored_start_diff", first_d, 16'h0002);
    check("diff_held_idle", diff, 16'h0002);

    // start held through DONE chains a second operation with no IDLE cycle
    run_op(16'hABCD, 16'h1111, 1'b0, 1'b1);
    run_op(16'h0100, 16'h0200, 1'b1, 1'b0);

    // asynchronous reset mid-operation
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0);
    a = 16'h1234;
    b = 16'h0234;
    bin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", diff, 0);
    check("midrst_bout", bout, 0);
    check("midrst_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(16'h0003, 16'h0001, 1'b0, 1'b0);
    check("post_rst_diff", diff, 16'h0002);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_borrow_subtractor.md
Name: nibble_borrow_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor: computes diff = a - b - bin, one 4-bit nibble per clock, LSB nibble first.
- Each nibble uses a combinational 4-bit borrow-look-ahead cell; the borrow is registered between cycles.
- Counterpart to the team's 4-bit carry-look-ahead adder; used where wide subtraction must share one small look-ahead slice.
- Start/busy/done handshake toward the datapath controller.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  minuend; captured on the accepted start.
- b  in  WIDTH  subtrahend; captured on the accepted start.
- bin  in  1  borrow-in; captured on the accepted start.
- busy  out  1  high while a subtraction is in progress.
- done  out  1  single-cycle pulse when the result is valid.
- diff  out  WIDTH  result; held from done until the next completion.
- bout  out  1  final borrow-out (unsigned a < b+bin).
- ovf  out  1  signed overflow: a[MSB]!=b[MSB] and diff[MSB]!=a[MSB].

Behaviour:
- Reset is asynchronous and active-low: clock is clk, reset is rst_n. Reset asserted at any time, including mid-operation, forces state=IDLE and clears busy, done, diff, bout, ovf, all operand registers, the nibble index and the borrow register to 0. No partial result survives reset.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 captures a, b, bin, sets idx=0, borrow=bin, busy=1, and moves to RUN.
  - RUN: each cycle, nibble idx goes through the look-ahead cell:
    - propagate p = ~(a_n ^ b_n); generate g = ~a_n & b_n.
    - Borrows are computed in parallel: b1 = g0 | p0&b0, and so on.
    - The difference nibble is written to the working register; borrow takes the nibble's borrow-out; idx increments.
    - After nibble NIB-1 the FSM goes to DONE.
  - DONE (one cycle): done=1, busy=0. diff, bout and ovf are loaded from the working state on the transition into DONE.
    - start=1 here is accepted: behaves as in IDLE and goes straight to RUN.
    - Otherwise the FSM returns to IDLE.
- Latency: done is high in the cycle following exactly NIB+1 rising edges after the edge that sampled start (WIDTH=16: 5 edges). Throughput is one result per NIB+1 cycles.
- start while busy=1 is ignored; it is not queued, and the captured operands stay unchanged.
- Changes on a, b or bin after capture have no effect.
- diff, bout and ovf change only on entry to DONE. They are stable in IDLE and throughout a subsequent RUN.
- Wrap-around is modulo 2^WIDTH. bout=1 whenever the true result is negative.

Optional Feature:
- Macro: NIBBLE_BORROW_SUBTRACTOR_CMP_EN.
- Defined: adds three outputs, each 1 bit wide and updated together with diff:
  - eq: diff==0 and bout==0.
  - ltu: equals bout.
  - lts: diff[MSB]^ovf.
  - All three reset to 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package nibble_borrow_subtractor_pkg holds:
  - the FSM state enum (IDLE/RUN/DONE);
  - the constant NIBBLE_W=4;
  - a function computing signed overflow from sign bits.
- One sub-module, borrow_la4: combinational 4-bit borrow-look-ahead cell.
  - Inputs: a[3:0], b[3:0], bi.
  - Outputs: d[3:0], bo.
  - Instantiated once in the top level.

Test Plan (WIDTH=16):
- a=0x1234, b=0x0234, bin=0, pulse start -> done exactly 5 edges later; diff=0x1000, bout=0, ovf=0; busy high for 4 cycles.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. With CMP_EN: ltu=1, lts=1, eq=0.
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. With CMP_EN: lts=1, ltu=0.
- a=0x00F0, b=0x000F, bin=1 -> diff=0x00E0, bout=0. Then a=b=0x5A5A, bin=0 -> diff=0x0000, bout=0, eq=1 (CMP_EN).
- Handshake checks:
  - Start with a=0x0005, b=0x0003, then change a/b and pulse start during RUN -> single result diff=0x0002.
  - Start held high through DONE -> second operation begins with no IDLE cycle.
- Reset mid-operation:
  - Drive rst_n low two cycles into RUN -> busy, done, diff, bout and ovf are 0 immediately (asynchronous).
  - After release, a fresh start with a=0x0003, b=0x0001 -> diff=0x0002 after 5 edges.
